rpm_setpoint_ctrl: RTL and testbench

//   Operator RPM setpoint unit: two raw active-low buttons step a registered setpoint up or down.
//   Per-button debounce, configurable step size, saturating min/max limits, external load, change strobe.

---
 rtl/rpm_setpoint_ctrl_if.sv | 36 +++
 rtl/rpm_setpoint_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_rpm_setpoint_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpm_setpoint_ctrl_if.sv
// Button, load and setpoint signals of the RPM setpoint unit.
// master drives buttons/load; slave is the setpoint controller.
interface rpm_setpoint_ctrl_if #(
    parameter int WIDTH = 7
);
    logic             btn_dec_n;
    logic             btn_inc_n;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] rpm;
    logic             rpm_changed;
    logic             at_min;
    logic             at_max;

    modport master (
        output btn_dec_n,
        output btn_inc_n,
        output load,
        output load_value,
        input  rpm,
        input  rpm_changed,
        input  at_min,
        input  at_max
    );

    modport slave (
        input  btn_dec_n,
        input  btn_inc_n,
        input  load,
        input  load_value,
        output rpm,
        output rpm_changed,
        output at_min,
        output at_max
    );
endinterface

// File: rtl/rpm_setpoint_ctrl.sv
// Debounced up/down RPM setpoint register with saturating limits and load.
// Define AUTO_REPEAT_EN to add hold-to-repeat stepping.
module rpm_setpoint_ctrl #(
    parameter int WIDTH           = 7,
    parameter int STEP            = 5,
    parameter int RPM_MIN         = 0,
    parameter int RPM_MAX         = 95,
    parameter int RPM_INIT        = 0,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input logic                clk,
    input logic                rst_n,
    rpm_setpoint_ctrl_if.slave bus
);

    if (STEP < 1 || STEP >= (1 << WIDTH)) begin : g_bad_step
        $error("rpm_setpoint_ctrl: STEP out of range");
    end
    if (RPM_MIN < 0 || RPM_MIN > RPM_MAX || RPM_MAX >= (1 << WIDTH)) begin : g_bad_lim
        $error("rpm_setpoint_ctrl: illegal RPM_MIN/RPM_MAX");
    end
    if (RPM_INIT < RPM_MIN || RPM_INIT > RPM_MAX) begin : g_bad_init
        $error("rpm_setpoint_ctrl: RPM_INIT outside limits");
    end
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cnt
        $error("rpm_setpoint_ctrl: illegal cycle counts");
    end

`ifdef AUTO_REPEAT_EN
    localparam int CNT_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX = (CNT_A > REPEAT_CYCLES) ? CNT_A : REPEAT_CYCLES;
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CW = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

    localparam logic [WIDTH:0]   STEP_W = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   MIN_W  = (WIDTH + 1)'(RPM_MIN);
    localparam logic [WIDTH:0]   MAX_W  = (WIDTH + 1)'(RPM_MAX);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(RPM_MIN);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(RPM_MAX);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(RPM_INIT);

`ifdef AUTO_REPEAT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_DEBOUNCE, S_HELD, S_REPEAT, S_RELEASE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE
    } state_t;
`endif

    typedef enum logic [1:0] {
        C_NONE = 2'b00,
        C_INC  = 2'b01,
        C_DEC  = 2'b10,
        C_BOTH = 2'b11
    } code_t;

    logic [1:0]       inc_sync_q;
    logic [1:0]       dec_sync_q;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] rpm_q, rpm_d;
    logic             chg_q, chg_d;

    code_t            code;
    logic             hit;
    logic             step_en;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH:0]   ld_diff;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] ld_val;

    // Synchroniser outputs are active-low; bit0 = inc, bit1 = dec pressed.
    assign code = code_t'({~dec_sync_q[1], ~inc_sync_q[1]});
    assign hit  = (code == (dir_q ? C_INC : C_DEC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_sync_q <= 2'b11;
            dec_sync_q <= 2'b11;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            rpm_q      <= INIT_V;
            chg_q      <= 1'b0;
        end else begin
            inc_sync_q <= {inc_sync_q[0], bus.btn_inc_n};
            dec_sync_q <= {dec_sync_q[0], bus.btn_dec_n};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            rpm_q      <= rpm_d;
            chg_q      <= chg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        step_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                unique case (code)
                    C_INC, C_DEC: begin
                        state_d = S_DEBOUNCE;
                        dir_d   = (code == C_INC);
                    end
                    C_BOTH:  state_d = S_RELEASE;
                    default: state_d = S_IDLE;
                endcase
            end
            S_DEBOUNCE: begin
                if (hit) begin
                    if (cnt_q == DEB_LAST) begin
                        step_en = 1'b1;
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = (code == C_NONE) ? S_IDLE : S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_HELD: begin
                if (!hit) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (cnt_q == HOLD_LAST) begin
                    step_en = 1'b1;
                    state_d = S_REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
`ifdef AUTO_REPEAT_EN
            S_REPEAT: begin
                if (!hit) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    step_en = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_RELEASE: begin
                if (code != C_NONE) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Limit tests use the sign bit of a WIDTH+1 difference, so nothing wraps.
    always_comb begin
        up_sum  = {1'b0, rpm_q} + STEP_W;
        dn_diff = {1'b0, rpm_q} - MIN_W - STEP_W;
        ld_diff = {1'b0, bus.load_value} - MIN_W;
        up_val  = (up_sum > MAX_W) ? MAX_V : up_sum[WIDTH-1:0];
        dn_val  = dn_diff[WIDTH] ? MIN_V : (rpm_q - STEP_V);
        if (bus.load_value > MAX_V) begin
            ld_val = MAX_V;
        end else if (ld_diff[WIDTH]) begin
            ld_val = MIN_V;
        end else begin
            ld_val = bus.load_value;
        end
    end

    always_comb begin
        rpm_d = rpm_q;
        if (bus.load) begin
            rpm_d = ld_val;
        end else if (step_en) begin
            rpm_d = dir_q ? up_val : dn_val;
        end
        chg_d = (rpm_d != rpm_q);
    end

    assign bus.rpm         = rpm_q;
    assign bus.rpm_changed = chg_q;
    assign bus.at_min      = (rpm_q == MIN_V);
    assign bus.at_max      = (rpm_q == MAX_V);

endmodule

// File: tb/tb_rpm_setpoint_ctrl.sv
// Bench for rpm_setpoint_ctrl: directed cases plus random button/load traffic
// checked every cycle against a behavioural model.
module tb_rpm_setpoint_ctrl;

    localparam int W    = 7;
    localparam int STEP = 5;
    localparam int MIN  = 0;
    localparam int MAX  = 95;
    localparam int INIT = 50;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    localparam int M_IDLE = 0;
    localparam int M_DEB  = 1;
    localparam int M_HELD = 2;
    localparam int M_REP  = 3;
    localparam int M_REL  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rpm_setpoint_ctrl_if #(.WIDTH(W)) bus ();

    rpm_setpoint_ctrl #(
        .WIDTH(W), .STEP(STEP), .RPM_MIN(MIN), .RPM_MAX(MAX),
        .RPM_INIT(INIT), .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_pulse = 0;

    int m_rpm, m_chg, m_mode, m_cnt, m_dir;
    bit m_s1i, m_s2i, m_s1d, m_s2d;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_rpm  = INIT;
        m_chg  = 0;
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_dir  = 0;
        m_s1i  = 1;
        m_s2i  = 1;
        m_s1d  = 1;
        m_s2d  = 1;
    endfunction

    function automatic void m_step(input bit inc_n, input bit dec_n,
                                   input bit ld, input int lv);
        int code;
        int nxt;
        bit hit;
        bit stp;
        code = (m_s2i ? 0 : 1) + (m_s2d ? 0 : 2);
        hit  = (code == (m_dir != 0 ? 1 : 2));
        stp  = 0;
        case (m_mode)
            M_IDLE: begin
                m_cnt = 0;
                if (code == 3) m_mode = M_REL;
                else if (code != 0) begin
                    m_mode = M_DEB;
                    m_dir  = (code == 1) ? 1 : 0;
                end
            end
            M_DEB: begin
                if (!hit) begin
                    m_mode = (code == 0) ? M_IDLE : M_REL;
                    m_cnt  = 0;
                end else if (m_cnt == DEB - 1) begin
                    stp    = 1;
                    m_mode = M_HELD;
                    m_cnt  = 0;
                end else m_cnt++;
            end
            M_HELD: begin
                if (!hit) begin
                    m_mode = M_REL;
                    m_cnt  = 0;
                end
`ifdef AUTO_REPEAT_EN
                else if (m_cnt == HOLD - 1) begin
                    stp    = 1;
                    m_mode = M_REP;
                    m_cnt  = 0;
                end else m_cnt++;
`endif
            end
            M_REP: begin
                if (!hit) begin
                    m_mode = M_REL;
                    m_cnt  = 0;
                end else if (m_cnt == REP - 1) begin
                    stp   = 1;
                    m_cnt = 0;
                end else m_cnt++;
            end
            default: begin
                if (code != 0) m_cnt = 0;
                else if (m_cnt == DEB - 1) begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end else m_cnt++;
            end
        endcase
        nxt = m_rpm;
        if (ld) nxt = (lv > MAX) ? MAX : ((lv < MIN) ? MIN : lv);
        else if (stp && m_dir != 0) nxt = (m_rpm + STEP > MAX) ? MAX : m_rpm + STEP;
        else if (stp) nxt = (m_rpm - STEP < MIN) ? MIN : m_rpm - STEP;
        m_chg = (nxt != m_rpm) ? 1 : 0;
        m_rpm = nxt;
        m_s2i = m_s1i;
        m_s1i = inc_n;
        m_s2d = m_s1d;
        m_s1d = dec_n;
    endfunction

    task automatic tick(input bit inc_n, input bit dec_n,
                        input bit ld = 1'b0, input int lv = 0);
        bus.btn_inc_n  = inc_n;
        bus.btn_dec_n  = dec_n;
        bus.load       = ld;
        bus.load_value = W'(lv);
        @(posedge clk);
        m_step(inc_n, dec_n, ld, lv);
        #1;
        chk("rpm", int'(bus.rpm), m_rpm);
        chk("rpm_changed", int'(bus.rpm_changed), m_chg);
        chk("at_min", int'(bus.at_min), (m_rpm == MIN) ? 1 : 0);
        chk("at_max", int'(bus.at_max), (m_rpm == MAX) ? 1 : 0);
        if (bus.rpm_changed) n_pulse++;
    endtask

    task automatic run(input bit inc_n, input bit dec_n, input int n);
        repeat (n) tick(inc_n, dec_n);
    endtask

    task automatic press(input bit inc, input int hold);
        run(!inc, inc, hold);
        run(1'b1, 1'b1, 12);
    endtask

    // Asserts reset between clock edges and releases it on a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 m_reset();
        chk("rst_rpm", int'(bus.rpm), INIT);
        chk("rst_chg", int'(bus.rpm_changed), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.btn_inc_n  = 1'b1;
        bus.btn_dec_n  = 1'b1;
        bus.load       = 1'b0;
        bus.load_value = '0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rpm", int'(bus.rpm), 50);
        chk("reset_chg", int'(bus.rpm_changed), 0);
        chk("reset_min", int'(bus.at_min), 0);
        chk("reset_max", int'(bus.at_max), 0);
        rst_n = 1'b1;

        n_pulse = 0;
        press(1'b1, 12);
        chk("inc_once_rpm", int'(bus.rpm), 55);
        chk("inc_once_pulses", n_pulse, 1);

        do_reset();
        n_pulse = 0;
        for (int i = 0; i < 7; i++) begin
            run(1'b0, 1'b1, 2);
            run(1'b1, 1'b1, 1);
        end
        run(1'b1, 1'b1, 12);
        chk("bounce_rpm", int'(bus.rpm), 50);
        chk("bounce_pulses", n_pulse, 0);

        tick(1'b1, 1'b1, 1'b1, 93);
        chk("load_rpm", int'(bus.rpm), 93);
        n_pulse = 0;
        press(1'b1, 12);
        chk("sat_rpm", int'(bus.rpm), 95);
        chk("sat_pulses", n_pulse, 1);
        n_pulse = 0;
        press(1'b1, 12);
        chk("at_limit_rpm", int'(bus.rpm), 95);
        chk("at_limit_max", int'(bus.at_max), 1);
        chk("at_limit_pulses", n_pulse, 0);
        tick(1'b1, 1'b1, 1'b1, 127);
        chk("load_clamp", int'(bus.rpm), 95);

        do_reset();
        n_pulse = 0;
        run(1'b0, 1'b0, 12);
        run(1'b1, 1'b0, 12);
        chk("both_rpm", int'(bus.rpm), 50);
        chk("both_pulses", n_pulse, 0);
        run(1'b1, 1'b1, 12);
        press(1'b0, 12);
        chk("after_both_rpm", int'(bus.rpm), 45);

        do_reset();
        n_pulse = 0;
        run(1'b1, 1'b0, 100);
`ifdef AUTO_REPEAT_EN
        chk("repeat_rpm", int'(bus.rpm), 0);
        chk("repeat_min", int'(bus.at_min), 1);
        chk("repeat_pulses", n_pulse, 10);
`else
        chk("hold_rpm", int'(bus.rpm), 45);
        chk("hold_pulses", n_pulse, 1);
`endif
        run(1'b1, 1'b1, 12);

        do_reset();
        run(1'b1, 1'b0, 45);
`ifdef AUTO_REPEAT_EN
        chk("pre_rst_rpm", int'(bus.rpm), 30);
`else
        chk("pre_rst_rpm", int'(bus.rpm), 45);
`endif
        do_reset();
        run(1'b1, 1'b1, 4);
        press(1'b1, 12);
        chk("post_rst_rpm", int'(bus.rpm), 55);

        do_reset();
        repeat (300) begin
            int  kind;
            int  dur;
            bit  ld;
            kind = $urandom_range(0, 3);
            dur  = $urandom_range(1, 30);
            for (int k = 0; k < dur; k++) begin
                ld = ($urandom_range(0, 19) == 0);
                tick(!(kind == 1 || kind == 3), !(kind == 2 || kind == 3),
                     ld, $urandom_range(0, 127));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
